ip_rx_ctrl: RTL
===============

IP_RX_CTRL -- requirements
Module: ip_rx_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- TIMEOUT_CYCLES, 1024, RUN-state watchdog limit in cycles.
- UDP_PROTO, 8'd17, protocol value routed to UDP.
- TCP_PROTO, 8'd6, protocol value routed to TCP.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on posedge.
- reset, in, 1, synchronous, active-high.
- req, in, 2, per-source packet request.
- src_data0, in, 32, source 0 word stream.
- src_data1, in, 32, source 1 word stream.
- grant, out, 2, one-hot owner of the decoder.
- dec_reset, out, 1, decoder reset.
- dec_start, out, 1, decoder start.
- dec_data, out, 32, muxed word to decoder.
- dec_fin, in, 1, decoder finished.
- dec_ok, in, 1, decoder header checksum good.
- dec_protocol, in, 8, decoded protocol field.
- pkt_done, out, 1, one-cycle end-of-packet pulse.
- pkt_good, out, 1, qualifies pkt_done.
- pkt_port, out, 1, source index of the finished packet.
- route_udp, out, 1, one-cycle UDP dispatch pulse.
- route_tcp, out, 1, one-cycle TCP dispatch pulse.
- drop_cnt, out, 16, saturating count of dropped packets.
- busy, out, 1, high whenever state is not IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, START, RUN, CHECK and RELEASE.
REQ-004 In IDLE with req nonzero, the FSM SHALL grant one source and enter START on the next edge.
- Single request: that source is granted.
- Both requesting: the source indicated by rr_ptr is granted.
REQ-005 grant SHALL be registered, one-hot, and held from START through RELEASE inclusive; deassertion of req while granted SHALL be ignored.
REQ-006 dec_data SHALL be combinationally muxed from the granted source while grant is nonzero, and SHALL be 0 otherwise.
REQ-007 In START, dec_start SHALL be 1 for exactly one cycle; the FSM then enters RUN.
REQ-008 In RUN, the FSM SHALL wait for dec_fin=1 and then enter CHECK.
REQ-009 In CHECK (one cycle), the block SHALL:
- pulse pkt_done=1;
- drive pkt_port = granted index;
- drive pkt_good = dec_ok;
- pulse route_udp iff dec_ok && dec_protocol==UDP_PROTO;
- pulse route_tcp iff dec_ok && dec_protocol==TCP_PROTO.
REQ-010 drop_cnt SHALL increment in CHECK when !dec_ok or the protocol matches neither constant, and SHALL saturate at 16'hFFFF.
REQ-011 In RELEASE (one cycle), the block SHALL assert dec_reset=1 and set rr_ptr to the non-granted index; grant SHALL be 0 from the following cycle, when the FSM returns to IDLE.
REQ-012 Minimum packet spacing SHALL be 2 cycles of IDLE→START after RELEASE; a new grant SHALL NOT be issued in RELEASE.
REQ-013 pkt_done, pkt_good, route_udp and route_tcp SHALL be 0 in every state except as specified above.

Reset
REQ-014 On reset the block SHALL be in IDLE with rr_ptr=0 and all outputs 0, except dec_reset=1 while reset is high; drop_cnt SHALL clear to 0.
REQ-015 Reset asserted mid-packet SHALL abort without a pkt_done pulse and without incrementing drop_cnt.

Configuration
REQ-016 With IP_RX_TIMEOUT_EN defined, a 16-bit watchdog SHALL clear on entering RUN and count in RUN; if it reaches TIMEOUT_CYCLES-1 without dec_fin, the block SHALL go to RELEASE, pulse pkt_done=1 with pkt_good=0, and increment drop_cnt.
REQ-017 Without IP_RX_TIMEOUT_EN, the watchdog SHALL be absent and RUN SHALL wait indefinitely.

Structure
REQ-018 Package ip_rx_pkg SHALL hold the state encoding type and the IP_PROTO_UDP and IP_PROTO_TCP constants.
REQ-019 Sub-module rr_arbiter2 (req, rr_ptr → one-hot grant) SHALL contain the arbitration logic.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- req=01, decoder fin+ok with proto 17 → grant=01, pkt_done with pkt_port=0, route_udp=1, drop_cnt=0.
- req=11 from reset → source 0 served first, then source 1 (rr_ptr), with exactly 2 idle-path cycles between the RELEASE and the next START.
- proto 6 with ok=0 → pkt_good=0, no route pulses, drop_cnt=1.
- drop_cnt preloaded to 16'hFFFF by 65535 drops, then a further drop → drop_cnt stays at 16'hFFFF.
- IP_RX_TIMEOUT_EN with TIMEOUT_CYCLES=8 and fin never asserted → pkt_done with pkt_good=0 after 8 RUN cycles, then dec_reset=1.
- reset asserted in RUN → grant=0, no pkt_done, drop_cnt unchanged, dec_reset=1 on the next cycle.

Source files
------------

// File: rtl/ip_rx_pkg.sv
//------------------------------------------------------------------------------
// ip_rx_pkg : controller state encoding and IP protocol constants
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ip_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_RUN     = 3'd2,
    ST_CHECK   = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  localparam logic [7:0] IP_PROTO_UDP = 8'd17;
  localparam logic [7:0] IP_PROTO_TCP = 8'd6;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
//------------------------------------------------------------------------------
// rr_arbiter2 : two-source one-hot arbiter, rr_ptr breaks ties
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ip_rx_ctrl.sv
//------------------------------------------------------------------------------
// ip_rx_ctrl : shares one IP header decoder between two word sources and
//              dispatches checked packets to UDP/TCP. IP_RX_TIMEOUT_EN adds a
//              RUN-state watchdog.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ip_rx_ctrl
  import ip_rx_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [7:0] UDP_PROTO      = IP_PROTO_UDP,
  parameter logic [7:0] TCP_PROTO      = IP_PROTO_TCP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [31:0] src_data0,
  input  logic [31:0] src_data1,
  output logic [1:0]  grant,
  output logic        dec_reset,
  output logic        dec_start,
  output logic [31:0] dec_data,
  input  logic        dec_fin,
  input  logic        dec_ok,
  input  logic [7:0]  dec_protocol,
  output logic        pkt_done,
  output logic        pkt_good,
  output logic        pkt_port,
  output logic        route_udp,
  output logic        route_tcp,
  output logic [15:0] drop_cnt,
  output logic        busy
);

  state_t      state;
  state_t      state_nx;
  logic [1:0]  grant_q;
  logic [1:0]  arb_grant;
  logic        rr_ptr;
  logic [15:0] drop_q;
  logic        timeout;
  logic        udp_hit;
  logic        tcp_hit;
  logic        in_check;
  logic        drop_evt;

  rr_arbiter2 u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .grant  (arb_grant)
  );

`ifdef IP_RX_TIMEOUT_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd;

  always_ff @(posedge clk) begin
    if (reset)                 wd <= 16'd0;
    else if (state == ST_START) wd <= 16'd0;
    else if (state == ST_RUN)   wd <= wd + 16'd1;
  end

  assign timeout = (state == ST_RUN) && !dec_fin && (wd == WD_LIMIT);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  assign udp_hit  = (dec_protocol == UDP_PROTO);
  assign tcp_hit  = (dec_protocol == TCP_PROTO);
  // Pulse outputs are suppressed while reset is high so an abort never reports.
  assign in_check = !reset && (state == ST_CHECK);
  assign drop_evt = (in_check && (!dec_ok || !(udp_hit || tcp_hit))) ||
                    (!reset && timeout);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      grant_q <= 2'b00;
      rr_ptr  <= 1'b0;
      drop_q  <= 16'd0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && req != 2'b00) grant_q <= arb_grant;
      else if (state == ST_RELEASE)         grant_q <= 2'b00;
      if (state == ST_RELEASE) rr_ptr <= ~grant_q[1];
      if (drop_evt && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (req != 2'b00) state_nx = ST_START;
      ST_START:   state_nx = ST_RUN;
      ST_RUN: begin
        if (dec_fin)      state_nx = ST_CHECK;
        else if (timeout) state_nx = ST_RELEASE;
      end
      ST_CHECK:   state_nx = ST_RELEASE;
      ST_RELEASE: state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    dec_data = 32'd0;
    if (grant_q[0])      dec_data = src_data0;
    else if (grant_q[1]) dec_data = src_data1;
  end

  assign grant     = grant_q;
  assign dec_reset = reset || (state == ST_RELEASE);
  assign dec_start = !reset && (state == ST_START);
  assign pkt_done  = in_check || (!reset && timeout);
  assign pkt_good  = in_check && dec_ok;
  assign pkt_port  = pkt_done && grant_q[1];
  assign route_udp = pkt_good && udp_hit;
  assign route_tcp = pkt_good && tcp_hit;
  assign drop_cnt  = drop_q;
  assign busy      = (state != ST_IDLE);

endmodule

`default_nettype wire
